// File: rtl/cam_pkg.sv
// Shared constants, FSM state type and pixel conversion for the camera capture path.
package cam_pkg;

    localparam int IMG_W_DEF = 160;
    localparam int IMG_H_DEF = 120;
    localparam int RGB_W     = 12;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LINE,
        BYTE1,
        BYTE2,
        LINE_END
    } cam_state_t;

    // RGB565 split over two bytes (hi=RRRRRGGG, lo=GGGBBBBB) reduced to RGB444.
    function automatic logic [RGB_W-1:0] rgb565_to_444(input logic [7:0] hi, input logic [7:0] lo);
        return {hi[7:4], hi[2:0], lo[7], lo[4:1]};
    endfunction

endpackage

// File: rtl/cam_read.sv
// Camera byte-stream capture into an RGB444 frame buffer with linear addressing.
// Optional colour-bar source enabled by defining CAM_TEST_PATTERN_EN.
module cam_read
    import cam_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int AW    = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CAM_vsync,
    input  logic             CAM_href,
    input  logic [7:0]       CAM_px_data,
`ifdef CAM_TEST_PATTERN_EN
    input  logic             test_pat,
`endif
    output logic [AW-1:0]    mem_px_addr,
    output logic [RGB_W-1:0] mem_px_data,
    output logic             px_wr,
    output logic             frame_done,
    output logic             overflow
);

    localparam int CW = $clog2(IMG_W + 1);
    localparam int RW = $clog2(IMG_H + 1);

    cam_state_t       state;
    logic             vsync_p0;
    logic [7:0]       hi_byte;
    logic [CW-1:0]    col;
    logic [RW-1:0]    row;
    logic [AW-1:0]    line_base;
    logic             line_wr;

    logic             vsync_rise;
    logic             vsync_fall;
    logic             in_bounds;
    logic [RGB_W-1:0] px_rgb;

`ifdef CAM_TEST_PATTERN_EN
    function automatic logic [RGB_W-1:0] colour_bar(input logic [CW-1:0] c);
        if (int'(c) < 53)
            return 12'hF00;
        else if (int'(c) < 106)
            return 12'h0F0;
        else
            return 12'h00F;
    endfunction
`endif

    assign vsync_rise = CAM_vsync & ~vsync_p0;
    assign vsync_fall = ~CAM_vsync & vsync_p0;
    assign in_bounds  = (col < CW'(IMG_W)) && (row < RW'(IMG_H));

`ifdef CAM_TEST_PATTERN_EN
    assign px_rgb = test_pat ? colour_bar(col) : rgb565_to_444(hi_byte, CAM_px_data);
`else
    assign px_rgb = rgb565_to_444(hi_byte, CAM_px_data);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            vsync_p0    <= 1'b0;
            hi_byte     <= '0;
            col         <= '0;
            row         <= '0;
            line_base   <= '0;
            line_wr     <= 1'b0;
            mem_px_addr <= '0;
            mem_px_data <= '0;
            px_wr       <= 1'b0;
            frame_done  <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            vsync_p0   <= CAM_vsync;
            px_wr      <= 1'b0;
            frame_done <= 1'b0;

            // A vsync rise outranks any href activity in the same cycle.
            if (state != IDLE && vsync_rise) begin
                state      <= IDLE;
                frame_done <= 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (vsync_fall) begin
                            row       <= '0;
                            col       <= '0;
                            line_base <= '0;
                            line_wr   <= 1'b0;
                            overflow  <= 1'b0;
                            state     <= WAIT_LINE;
                        end
                    end
                    WAIT_LINE: begin
                        if (CAM_href) begin
                            hi_byte <= CAM_px_data;
                            state   <= BYTE2;
                        end
                    end
                    BYTE2: begin
                        if (CAM_href) begin
                            if (in_bounds) begin
                                px_wr       <= 1'b1;
                                mem_px_addr <= line_base + AW'(col);
                                mem_px_data <= px_rgb;
                                line_wr     <= 1'b1;
                            end else begin
                                overflow <= 1'b1;
                            end
                            if (col < CW'(IMG_W))
                                col <= col + 1'b1;
                            state <= BYTE1;
                        end else begin
                            state <= LINE_END;
                        end
                    end
                    BYTE1: begin
                        if (CAM_href) begin
                            hi_byte <= CAM_px_data;
                            state   <= BYTE2;
                        end else begin
                            state <= LINE_END;
                        end
                    end
                    LINE_END: begin
                        col     <= '0;
                        line_wr <= 1'b0;
                        // Empty lines do not consume a row of the buffer.
                        if (line_wr && row < RW'(IMG_H)) begin
                            row       <= row + 1'b1;
                            line_base <= line_base + AW'(IMG_W);
                        end
                        state <= WAIT_LINE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_read.sv
// Randomised directed bench for cam_read with a frame-level reference model.
// Exercises the colour-bar source too when CAM_TEST_PATTERN_EN is defined.
module tb_cam_read;

    localparam int IMG_W = 160;
    localparam int IMG_H = 120;
    localparam int AW    = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          CAM_vsync;
    logic          CAM_href;
    logic [7:0]    CAM_px_data;
`ifdef CAM_TEST_PATTERN_EN
    logic          test_pat;
`endif
    logic [AW-1:0] mem_px_addr;
    logic [11:0]   mem_px_data;
    logic          px_wr;
    logic          frame_done;
    logic          overflow;

    cam_read #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .CAM_vsync   (CAM_vsync),
        .CAM_href    (CAM_href),
        .CAM_px_data (CAM_px_data),
`ifdef CAM_TEST_PATTERN_EN
        .test_pat    (test_pat),
`endif
        .mem_px_addr (mem_px_addr),
        .mem_px_data (mem_px_data),
        .px_wr       (px_wr),
        .frame_done  (frame_done),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int fd_cnt = 0;
    int got_q[$];
    int exp_q[$];

    // Reference model state: frame active, current row, sticky overflow, pattern mode.
    bit active_m = 0;
    int row_m    = 0;
    bit ovf_m    = 0;
    bit tp_m     = 0;

    always @(negedge clk) begin
        if (px_wr === 1'b1)
            got_q.push_back(int'(mem_px_addr) * 4096 + int'(mem_px_data));
        if (frame_done === 1'b1)
            fd_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_px(input int hi, input int lo, input int c, input bit tp);
        int r, g, b;
        if (tp) begin
            if (c < 53) return 'hF00;
            if (c < 106) return 'h0F0;
            return 'h00F;
        end
        r = hi / 16;
        g = (hi % 8) * 2 + lo / 128;
        b = (lo % 32) / 2;
        return r * 256 + g * 16 + b;
    endfunction

    task automatic frame_start();
        CAM_href  = 1'b0;
        CAM_vsync = 1'b1;
        repeat (2) @(negedge clk);
        CAM_vsync = 1'b0;
        repeat (2) @(negedge clk);
        active_m = 1;
        row_m    = 0;
        ovf_m    = 0;
    endtask

    task automatic frame_end(input string tag, input bit expect_fd);
        CAM_href  = 1'b0;
        CAM_vsync = 1'b1;
        @(negedge clk);
        check({tag, "_fd_pulse"}, frame_done, expect_fd);
        @(negedge clk);
        check({tag, "_fd_clear"}, frame_done, 0);
        active_m = 0;
    endtask

    // mode 0: constant 8'hF0, mode 1: random bytes. rst pulses on byte rst_at.
    task automatic drive_line(input int nbytes, input int mode, input int rst_at);
        int b, hi;
        bit wrote;
        wrote = 0;
        hi = 0;
        for (int i = 0; i < nbytes; i++) begin
            b = (mode == 0) ? 'hF0 : int'($urandom_range(0, 255));
            CAM_href    = 1'b1;
            CAM_px_data = 8'(b);
            rst         = (i == rst_at);
            @(negedge clk);
            rst = 1'b0;
            if (i == rst_at) active_m = 0;
            if (active_m) begin
                if (i % 2 == 0) begin
                    hi = b;
                end else if (i / 2 < IMG_W && row_m < IMG_H) begin
                    exp_q.push_back((row_m * IMG_W + i / 2) * 4096 + exp_px(hi, b, i / 2, tp_m));
                    wrote = 1;
                end else begin
                    ovf_m = 1;
                end
            end
        end
        CAM_href = 1'b0;
        repeat (3) @(negedge clk);
        if (active_m && wrote) row_m++;
    endtask

    task automatic verify(input string tag);
        int bad, n;
        bad = -1;
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < n; i++)
            if (got_q[i] != exp_q[i] && bad < 0) bad = i;
        check({tag, "_first_bad_index"}, bad, -1);
        check({tag, "_overflow"}, overflow, ovf_m);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int b0, b1, b2;
        rst = 1'b1;
        CAM_vsync = 1'b0;
        CAM_href = 1'b0;
        CAM_px_data = 8'h00;
`ifdef CAM_TEST_PATTERN_EN
        test_pat = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_addr", mem_px_addr, 0);
        check("rst_data", mem_px_data, 0);
        check("rst_px_wr", px_wr, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_overflow", overflow, 0);

        // Full frame of constant bytes
        fd_cnt = 0;
        frame_start();
        for (int l = 0; l < IMG_H; l++) drive_line(2 * IMG_W, 0, -1);
        frame_end("t1", 1);
        check("t1_writes", got_q.size(), 19200);
        check("t1_last_addr", (got_q.size() > 0) ? got_q[$] / 4096 : -1, 19199);
        check("t1_last_data", (got_q.size() > 0) ? got_q[$] % 4096 : -1, 'hF18);
        check("t1_frame_done_count", fd_cnt, 1);
        verify("t1");

        // Strobe latency against the low byte
        frame_start();
        CAM_href = 1'b1;
        CAM_px_data = 8'hFF;
        @(negedge clk);
        check("t2_hi_no_wr", px_wr, 0);
        @(negedge clk);
        check("t2_wr1", px_wr, 1);
        check("t2_data1", mem_px_data, 'hFFF);
        check("t2_addr1", mem_px_addr, 0);
        CAM_px_data = 8'h00;
        @(negedge clk);
        check("t2_hi2_no_wr", px_wr, 0);
        @(negedge clk);
        check("t2_wr2", px_wr, 1);
        check("t2_data2", mem_px_data, 'h000);
        check("t2_addr2", mem_px_addr, 1);
        CAM_href = 1'b0;
        repeat (3) @(negedge clk);
        frame_end("t2", 1);
        got_q.delete();

        // Over-long line, then following lines continue at the next row
        frame_start();
        drive_line(2 * IMG_W + 2, 1, -1);
        check("t3_ovf_set", overflow, 1);
        drive_line(6, 1, -1);
        drive_line(5, 1, -1);
        drive_line(4, 1, -1);
        frame_end("t3", 1);
        verify("t3");

        // Odd-length first line, overflow cleared by new frame
        frame_start();
        check("t4_ovf_clear", overflow, 0);
        drive_line(5, 1, -1);
        drive_line(4, 1, -1);
        frame_end("t4", 1);
        verify("t4");

        // vsync abort after 10 lines, colliding with an href low byte
        frame_start();
        for (int l = 0; l < 10; l++) drive_line(40, 1, -1);
        b0 = int'($urandom_range(0, 255));
        b1 = int'($urandom_range(0, 255));
        b2 = int'($urandom_range(0, 255));
        CAM_href = 1'b1;
        CAM_px_data = 8'(b0); @(negedge clk);
        CAM_px_data = 8'(b1); @(negedge clk);
        CAM_px_data = 8'(b2); @(negedge clk);
        exp_q.push_back((10 * IMG_W) * 4096 + exp_px(b0, b1, 0, 0));
        CAM_vsync = 1'b1;
        CAM_px_data = 8'h5A;
        @(negedge clk);
        check("t5_abort_fd", frame_done, 1);
        CAM_href = 1'b0;
        @(negedge clk);
        check("t5_abort_fd_clear", frame_done, 0);
        active_m = 0;
        verify("t5");
        frame_start();
        drive_line(8, 1, -1);
        frame_end("t5b", 1);
        verify("t5b");

        // Row overflow: one line more than the frame holds
        frame_start();
        for (int l = 0; l < IMG_H + 1; l++) drive_line(4, 1, -1);
        frame_end("t6", 1);
        verify("t6");

        // Reset during line 3 blocks capture until a fresh frame start
        frame_start();
        drive_line(20, 1, -1);
        drive_line(20, 1, -1);
        drive_line(40, 1, 10);
        drive_line(20, 1, -1);
        frame_end("t7", 0);
        verify("t7");
        frame_start();
        drive_line(6, 1, -1);
        frame_end("t7b", 1);
        verify("t7b");

`ifdef CAM_TEST_PATTERN_EN
        test_pat = 1'b1;
        tp_m = 1;
        frame_start();
        drive_line(2 * IMG_W, 1, -1);
        frame_end("t8", 1);
        verify("t8");
        test_pat = 1'b0;
        tp_m = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cam_read.md
Name: cam_read

Overview:
- Capture stage between the OV7670-style camera pins and the RGB444 frame buffer that the VGA side of test_cam reads.
- Pairs the RGB565 byte stream (two bytes per pixel, 160x120 frame) into one 12-bit RGB444 word.
- Writes each word to the buffer with a computed linear address.
- Frame/line timing comes from CAM_vsync and CAM_href.

Parameters:
- IMG_W, 160, pixels per line (href window carries 2*IMG_W bytes)
- IMG_H, 120, lines per frame
- AW, 15, address width (2^AW >= IMG_W*IMG_H)

Ports:
- clk  in  1  capture clock, driven from camera pixel clock
- rst  in  1  synchronous active-high reset
- CAM_vsync  in  1  high = vertical blanking; falling edge starts frame
- CAM_href  in  1  high = valid bytes on CAM_px_data
- CAM_px_data  in  8  camera byte, RGB565 high byte first
- mem_px_addr  out  AW  write address, row*IMG_W+col
- mem_px_data  out  12  RGB444 {R[3:0],G[3:0],B[3:0]}
- px_wr  out  1  one-cycle write strobe
- frame_done  out  1  one-cycle pulse at end of frame
- overflow  out  1  sticky per frame: a pixel fell outside IMG_W x IMG_H

Behaviour:
- Reset values: mem_px_addr=0, mem_px_data=0, px_wr=0, frame_done=0, overflow=0, state=IDLE. Counters and byte phase are cleared.
- All inputs are sampled on the rising edge of clk. Edges are detected against a one-cycle registered copy of each input.
- FSM states:
  - IDLE: wait for a CAM_vsync falling edge; then row=0, line_base=0, overflow=0, go to WAIT_LINE.
  - WAIT_LINE: on CAM_href=1, capture the byte as high byte and go to BYTE2. A CAM_vsync rising edge goes to IDLE and pulses frame_done.
  - BYTE2: if CAM_href=1, capture the low byte, emit the pixel, go to BYTE1. If CAM_href=0, go to LINE_END; the odd trailing byte is discarded.
  - BYTE1: if CAM_href=1, capture the high byte, go to BYTE2. If CAM_href=0, go to LINE_END.
  - LINE_END (1 cycle): col=0; if the line wrote at least one pixel, then row++ and line_base+=IMG_W; go to WAIT_LINE.
- Conversion: hi=RRRRRGGG, lo=GGGBBBBB. R444=hi[7:4], G444={hi[2:0],lo[7]}, B444=lo[4:1].
- Emit timing: px_wr=1 exactly one cycle after the low byte is sampled (registered outputs). mem_px_addr=line_base+col and mem_px_data are valid in that same cycle. col increments after each emit.
- No multiplier: the address is formed from the line_base accumulator plus col.
- Bounds: if col>=IMG_W or row>=IMG_H, px_wr stays 0, the pixel is dropped and overflow=1. col saturates at IMG_W and row saturates at IMG_H.
- CAM_vsync rising edge in any state other than IDLE: abort the partial pixel, pulse frame_done the next cycle, return to IDLE. A short frame is not padded.
- CAM_vsync and CAM_href changing in the same cycle: vsync takes priority.
- rst asserted mid-frame: all state clears next edge and no px_wr is issued. Capture resumes only after a fresh CAM_vsync falling edge.
- Between frames, overflow holds its value; it clears at the next frame start.

Optional Feature:
- Macro: CAM_TEST_PATTERN_EN.
- When defined: adds input test_pat (1 bit). While test_pat=1, mem_px_data is replaced by colour bars: col<53 gives 12'hF00, col<106 gives 12'h0F0, otherwise 12'h00F. Timing, addresses and strobes are unchanged.
- When undefined: no test_pat port and camera data is always used.

Decomposition:
- Package cam_pkg:
  - constants IMG_W_DEF=160, IMG_H_DEF=120, RGB_W=12
  - state enum {IDLE, WAIT_LINE, BYTE1, BYTE2, LINE_END}
  - pure function rgb565_to_444(hi,lo)
- No sub-module: edge detect, FSM and address generation fit in one module.

Test Plan:
- Constant byte 8'hF0, frame of 120 lines x 320 bytes: 19200 px_wr strobes, every mem_px_data=12'hF18, last mem_px_addr=19199, one frame_done, overflow=0.
- Byte pair 8'hFF,8'hFF then 8'h00,8'h00: data 12'hFFF then 12'h000; px_wr lags the low byte by exactly one clk.
- Line of 322 bytes (161 pixels): pixel 161 dropped, overflow=1, next line starts at addr 160.
- Line of 5 bytes: 2 pixels written at addr 0 and 1, trailing byte discarded, next line base=160.
- CAM_vsync rises after 10 lines: frame_done pulses and the FSM returns to IDLE. After the next vsync fall, first px_wr addr=0 and overflow=0.
- rst pulsed during line 3: no px_wr until a new vsync falling edge. The first pixel after that goes to addr 0; with CAM_TEST_PATTERN_EN and test_pat=1, col 0, 60 and 120 give 12'hF00, 12'h0F0 and 12'h00F.
